// File: rtl/cnt_timer.sv
// Compare-match timer driven by an external free-running cycle count.
// Supports one-shot or periodic reload, sticky W1C status bits and a registered interrupt.
module cnt_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cnt,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_e;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_CMP    = 2'd1;
    localparam logic [1:0] A_PERIOD = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    state_e      state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;        // {IRQ_EN, PERIODIC, EN}
    logic [31:0] cmp_q, cmp_d;
    logic [31:0] period_q, period_d;
    logic        match_q, match_d;
    logic        ovr_q, ovr_d;
    logic        irq_q, irq_d;

    logic wr_ctrl, wr_cmp, wr_period, wr_status;
    logic clr_match, clr_ovr, hit;

    // Register bus: a write is performed on the rising edge whenever we is high.
    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_cmp    = we && (addr == A_CMP);
    assign wr_period = we && (addr == A_PERIOD);
    assign wr_status = we && (addr == A_STATUS);
    assign clr_match = wr_status && wdata[0];
    assign clr_ovr   = wr_status && wdata[1];

    // Only ARMED can hit, so enabling in the same cycle as cnt==CMP produces no hit.
    assign hit = (state_q == ARMED) && (cnt == cmp_q);

    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            IDLE:    if (wr_ctrl && wdata[0]) state_d = ARMED;
            ARMED:   if (hit && !ctrl_q[1])   state_d = FIRED;
            FIRED:   if (clr_match)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
        if (wr_ctrl && !wdata[0]) begin
            state_d = IDLE;
        end
    end

    always_comb begin : regs_next
        ctrl_d   = ctrl_q;
        cmp_d    = cmp_q;
        period_d = period_q;
        match_d  = match_q;
        ovr_d    = ovr_q;
        irq_d    = match_q && ctrl_q[2];

        if (wr_ctrl) ctrl_d = wdata[2:0];
        if (hit && !ctrl_q[1]) ctrl_d[0] = 1'b0;

        // A software CMP write beats the periodic reload in the same cycle.
        if (wr_cmp) begin
            cmp_d = wdata;
        end else if (hit && ctrl_q[1]) begin
            cmp_d = cmp_q + period_q;
        end

        if (wr_period) period_d = wdata;

        // Hit beats W1C; a hit racing a MATCH clear is not counted as an overrun.
        if (hit) begin
            match_d = 1'b1;
        end else if (clr_match) begin
            match_d = 1'b0;
        end

        if (hit && match_q && !clr_match) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ctrl_q   <= 3'd0;
            cmp_q    <= 32'hFFFF_FFFF;
            period_q <= 32'd0;
            match_q  <= 1'b0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            cmp_q    <= cmp_d;
            period_q <= period_d;
            match_q  <= match_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin : read_mux
        rdata = 32'd0;
        case (addr)
            A_CTRL:   rdata = {29'd0, ctrl_q};
            A_CMP:    rdata = cmp_q;
            A_PERIOD: rdata = period_q;
            default:  rdata = {28'd0, state_q, ovr_q, match_q};
        endcase
    end

    assign irq       = irq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cnt_timer.sv
// Self-checking bench for cnt_timer: directed scenarios plus a randomized run
// compared against a register-level behavioural model.
module tb_cnt_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cnt;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [31:0] cnt_v;
    logic [31:0] exp_q[$];

    // Behavioural model of the programmer-visible state.
    bit          m_en, m_per, m_ien, m_match, m_ovr, m_irq;
    logic [31:0] m_cmp, m_period;
    int          m_st;

    cnt_timer dut (
        .clk       (clk),
        .reset     (reset),
        .cnt       (cnt),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic void model_reset();
        m_en = 0; m_per = 0; m_ien = 0;
        m_match = 0; m_ovr = 0; m_irq = 0;
        m_cmp = 32'hFFFF_FFFF;
        m_period = 32'd0;
        m_st = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_ien, m_per, m_en};
            2'd1:    return m_cmp;
            2'd2:    return m_period;
            default: return {28'd0, m_st[1:0], m_ovr, m_match};
        endcase
    endfunction

    function automatic void model_step(input bit w, input logic [1:0] a,
                                       input logic [31:0] d, input logic [31:0] c);
        bit hit, wc, clr_m, clr_o;
        bit n_en, n_per, n_ien, n_match, n_ovr, n_irq;
        logic [31:0] n_cmp, n_period;
        int n_st;
        hit   = (m_st == 1) && (c == m_cmp);
        wc    = w && (a == 2'd0);
        clr_m = w && (a == 2'd3) && d[0];
        clr_o = w && (a == 2'd3) && d[1];
        n_irq = m_match && m_ien;
        n_en  = wc ? d[0] : m_en;
        n_per = wc ? d[1] : m_per;
        n_ien = wc ? d[2] : m_ien;
        n_cmp = (w && a == 2'd1) ? d : ((hit && m_per) ? m_cmp + m_period : m_cmp);
        n_period = (w && a == 2'd2) ? d : m_period;
        n_match  = hit ? 1'b1 : (clr_m ? 1'b0 : m_match);
        n_ovr    = (hit && m_match && !clr_m) ? 1'b1 : (clr_o ? 1'b0 : m_ovr);
        n_st = m_st;
        if (m_st == 0 && wc && d[0]) n_st = 1;
        if (hit && !m_per) begin
            n_st = 2;
            n_en = 0;
        end
        if (m_st == 2 && clr_m) n_st = 0;
        if (wc && !d[0]) n_st = 0;
        m_en = n_en; m_per = n_per; m_ien = n_ien;
        m_cmp = n_cmp; m_period = n_period;
        m_match = n_match; m_ovr = n_ovr; m_irq = n_irq; m_st = n_st;
    endfunction

    // ---------------- drivers ----------------
    task automatic step(input bit w, input logic [1:0] a, input logic [31:0] d);
        we = w; addr = a; wdata = d; cnt = cnt_v;
        model_step(w, a, d, cnt_v);
        @(posedge clk); #1;
        we = 1'b0; wdata = 32'd0; cnt_v = cnt_v + 32'd1;
    endtask

    task automatic reset_dut();
        reset = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rst_exp [4];
        rst_exp = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
        reset = 1'b0; cnt_v = 32'd0; cnt = 32'd0;
        we = 1'b1; addr = 2'd1; wdata = 32'h1234;
        model_reset();
        @(posedge clk); #1;
        we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = i[1:0]; #1;
            checks++;
            if (rdata !== rst_exp[i]) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h exp=%h", i, rdata, rst_exp[i]);
            end
        end
        checks++;
        if (irq !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_irq_state got=%b/%0d exp=0/0", irq, dbg_state);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_oneshot();
        reset_dut();
        step(1, 2'd1, 32'd100);
        step(1, 2'd0, 32'h5);
        cnt_v = 32'd90;
        repeat (10) step(0, 2'd0, 32'd0);
        addr = 2'd3; #1; checks++;
        if (rdata !== 32'h4) begin
            failures++; $display("FAIL oneshot_pre got=%h exp=%h", rdata, 32'h4);
        end
        step(0, 2'd0, 32'd0);                 // cnt == 100 presented
        addr = 2'd3; #1; checks++;
        if (rdata !== 32'h9 || irq !== 1'b0) begin
            failures++; $display("FAIL oneshot_hit got=%h/%b exp=%h/0", rdata, irq, 32'h9);
        end
        addr = 2'd0; #1; checks++;
        if (rdata !== 32'h4 || dbg_state !== 2'd2) begin
            failures++; $display("FAIL oneshot_ctrl got=%h/%0d exp=%h/2", rdata, dbg_state, 32'h4);
        end
        step(0, 2'd0, 32'd0);
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL oneshot_irq got=%b exp=1", irq);
        end
    endtask

    task automatic test_w1c_fired();
        step(1, 2'd3, 32'h1);
        addr = 2'd3; #1; checks++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL w1c_status got=%h exp=%h", rdata, 32'h0);
        end
        step(0, 2'd0, 32'd0);
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL w1c_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_periodic();
        logic [31:0] c;
        reset_dut();
        step(1, 2'd1, 32'd50);
        step(1, 2'd2, 32'd20);
        step(1, 2'd0, 32'h7);
        cnt_v = 32'd45;
        while (cnt_v <= 32'd95) begin
            c = cnt_v;
            step(0, 2'd0, 32'd0);
            addr = 2'd3; #1;
            if (c == 32'd50) begin
                checks++;
                if (rdata !== 32'h5) begin
                    failures++; $display("FAIL periodic_hit50 got=%h exp=%h", rdata, 32'h5);
                end
            end
            if (c == 32'd70) begin
                checks++;
                if (rdata !== 32'h7) begin
                    failures++; $display("FAIL periodic_ovr70 got=%h exp=%h", rdata, 32'h7);
                end
            end
            addr = 2'd1; #1;
            if (c == 32'd90) begin
                checks++;
                if (rdata !== 32'd110) begin
                    failures++; $display("FAIL periodic_cmp got=%0d exp=110", rdata);
                end
            end
            checks++;
            if (irq !== m_irq) begin
                failures++; $display("FAIL periodic_irq cnt=%0d got=%b exp=%b", c, irq, m_irq);
            end
        end
        step(1, 2'd3, 32'h3);                 // clear both flags away from a hit
        cnt_v = 32'd110;
        step(1, 2'd3, 32'h1);                 // W1C races the hit at 110
        addr = 2'd3; #1; checks++;
        if (rdata !== 32'h5) begin
            failures++; $display("FAIL w1c_race got=%h exp=%h", rdata, 32'h5);
        end
        addr = 2'd1; #1; checks++;
        if (rdata !== 32'd130) begin
            failures++; $display("FAIL w1c_race_cmp got=%0d exp=130", rdata);
        end
    endtask

    task automatic test_cmp_collision();
        cnt_v = 32'd130;
        step(1, 2'd1, 32'd500);
        addr = 2'd1; #1; checks++;
        if (rdata !== 32'd500) begin
            failures++; $display("FAIL cmp_collide got=%0d exp=500", rdata);
        end
        addr = 2'd3; #1; checks++;
        if (rdata !== 32'h7) begin
            failures++; $display("FAIL cmp_collide_status got=%h exp=%h", rdata, 32'h7);
        end
    endtask

    task automatic test_en_collision();
        reset_dut();
        step(1, 2'd1, 32'd200);
        cnt_v = 32'd200;
        step(1, 2'd0, 32'h1);
        step(0, 2'd0, 32'd0);
        addr = 2'd3; #1; checks++;
        if (rdata !== 32'h4) begin
            failures++; $display("FAIL en_collide got=%h exp=%h", rdata, 32'h4);
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        step(1, 2'd2, 32'd64);
        step(1, 2'd1, 32'd0);
        step(1, 2'd0, 32'h3);
        cnt_v = 32'hFFFF_FFFE;
        step(0, 2'd0, 32'd0);
        step(0, 2'd0, 32'd0);
        addr = 2'd3; #1; checks++;
        if (rdata !== 32'h4) begin
            failures++; $display("FAIL wrap_pre got=%h exp=%h", rdata, 32'h4);
        end
        step(0, 2'd0, 32'd0);                 // cnt == 0
        addr = 2'd3; #1; checks++;
        if (rdata !== 32'h5) begin
            failures++; $display("FAIL wrap_hit got=%h exp=%h", rdata, 32'h5);
        end
        addr = 2'd1; #1; checks++;
        if (rdata !== 32'd64) begin
            failures++; $display("FAIL wrap_cmp got=%0d exp=64", rdata);
        end
    endtask

    task automatic test_period_zero();
        reset_dut();
        step(1, 2'd2, 32'd0);
        step(1, 2'd1, 32'd10);
        step(1, 2'd0, 32'h3);
        cnt_v = 32'd10;
        step(0, 2'd0, 32'd0);
        addr = 2'd1; #1; checks++;
        if (rdata !== 32'd10) begin
            failures++; $display("FAIL pzero_cmp got=%0d exp=10", rdata);
        end
        step(1, 2'd3, 32'h1);
        repeat (30) step(0, 2'd0, 32'd0);
        addr = 2'd3; #1; checks++;
        if (rdata !== 32'h4) begin
            failures++; $display("FAIL pzero_nohit got=%h exp=%h", rdata, 32'h4);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        step(1, 2'd1, 32'd20);
        step(1, 2'd0, 32'h7);
        cnt_v = 32'd20;
        step(0, 2'd0, 32'd0);
        step(0, 2'd0, 32'd0);
        checks++;
        if (irq !== 1'b1 || dbg_state !== 2'd1) begin
            failures++; $display("FAIL rstmid_pre got=%b/%0d exp=1/1", irq, dbg_state);
        end
        reset = 1'b0; addr = 2'd0; #1;
        checks++;
        if (irq !== 1'b0 || rdata !== 32'd0) begin
            failures++; $display("FAIL rstmid_async got=%b/%h exp=0/0", irq, rdata);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        addr = 2'd1; #1; checks++;
        if (rdata !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL rstmid_cmp got=%h exp=ffffffff", rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        reset_dut();
        cnt_v = $urandom;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       step(1, 2'd0, 32'($urandom_range(0, 7)));
                1:       step(1, 2'd1, cnt_v + 32'($urandom_range(1, 12)));
                2:       step(1, 2'd2, 32'($urandom_range(0, 10)));
                3:       step(1, 2'd3, 32'($urandom_range(0, 3)));
                4:       step(1, 2'd0, 32'($urandom_range(5, 7)));
                default: step(0, 2'($urandom_range(0, 3)), 32'd0);
            endcase
            exp_q.push_back(model_read(2'd3));
            exp_q.push_back(model_read(2'd1));
            addr = 2'd3; #1;
            e = exp_q.pop_front();
            checks++;
            if (rdata !== e) begin
                failures++; $display("FAIL rand_status it=%0d got=%h exp=%h", i, rdata, e);
            end
            addr = 2'd1; #1;
            e = exp_q.pop_front();
            checks++;
            if (rdata !== e) begin
                failures++; $display("FAIL rand_cmp it=%0d got=%h exp=%h", i, rdata, e);
            end
            checks++;
            if (irq !== m_irq) begin
                failures++; $display("FAIL rand_irq it=%0d got=%b exp=%b", i, irq, m_irq);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0; cnt = 32'd0; cnt_v = 32'd0;
        test_reset();
        test_oneshot();
        test_w1c_fired();
        test_periodic();
        test_cmp_collision();
        test_en_collision();
        test_wrap();
        test_period_zero();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
